// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the CPU and the display engine.
// Serializes single-word requests and returns read data with a one-cycle valid strobe.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dsp_req,
  input  logic              dsp_we,
  input  logic [ADDR_W-1:0] dsp_addr,
  input  logic [DATA_W-1:0] dsp_wdata,
  output logic              dsp_gnt,
  output logic              dsp_rvalid,
  output logic [DATA_W-1:0] dsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t             state;
  logic               owner_dsp;
  logic               last_dsp;
  logic               lat_we;
  logic [CNT_W-1:0]   cnt;
  logic               win_dsp;

  // On a tie the port not granted last wins.
  assign win_dsp = dsp_req && (!cpu_req || !last_dsp);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner_dsp  <= 1'b0;
      last_dsp   <= 1'b1;
      lat_we     <= 1'b0;
      cnt        <= '0;
      cpu_gnt    <= 1'b0;
      dsp_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      dsp_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dsp_rdata  <= '0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      // Strobes and the memory port are only ever active for a single cycle.
      cpu_gnt    <= 1'b0;
      dsp_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      dsp_rvalid <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      mem_wdata  <= '0;
      case (state)
        IDLE: begin
          if (cpu_req || dsp_req) begin
            owner_dsp <= win_dsp;
            last_dsp  <= win_dsp;
            lat_we    <= win_dsp ? dsp_we : cpu_we;
            mem_addr  <= win_dsp ? dsp_addr : cpu_addr;
            mem_wdata <= win_dsp ? dsp_wdata : cpu_wdata;
            mem_we    <= win_dsp ? dsp_we : cpu_we;
            mem_re    <= win_dsp ? !dsp_we : !cpu_we;
            cpu_gnt   <= !win_dsp;
            dsp_gnt   <= win_dsp;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (lat_we) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt   <= CNT_W'(RD_LAT);
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            if (owner_dsp) begin
              dsp_rdata  <= mem_rdata;
              dsp_rvalid <= 1'b1;
            end else begin
              cpu_rdata  <= mem_rdata;
              cpu_rvalid <= 1'b1;
            end
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter against a transaction-level schedule model.
module tb_mem_port_arbiter;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RD_LAT = 3;
  localparam int MAXC = 4096;
  localparam logic [DATA_W-1:0] POISON = 32'h0BAD_F00D;

  logic clk = 1'b0;
  logic reset;
  logic cpu_req, cpu_we, dsp_req, dsp_we;
  logic [ADDR_W-1:0] cpu_addr, dsp_addr, mem_addr;
  logic [DATA_W-1:0] cpu_wdata, dsp_wdata, cpu_rdata, dsp_rdata, mem_wdata, mem_rdata;
  logic cpu_gnt, dsp_gnt, cpu_rvalid, dsp_rvalid, mem_we, mem_re, busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dsp_req(dsp_req), .dsp_we(dsp_we), .dsp_addr(dsp_addr), .dsp_wdata(dsp_wdata),
    .dsp_gnt(dsp_gnt), .dsp_rvalid(dsp_rvalid), .dsp_rdata(dsp_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [DATA_W-1:0] init_val(input int i);
    return DATA_W'(i) * 32'h9E37_79B1;
  endfunction

  // Memory macro model: fixed read latency, contents re-initialised on reset.
  logic [DATA_W-1:0] dmem [256];
  logic [DATA_W-1:0] pipe [RD_LAT];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) dmem[i] <= init_val(i);
    end else if (mem_we) begin
      dmem[mem_addr] <= mem_wdata;
    end
    pipe[0] <= mem_re ? dmem[mem_addr] : POISON;
    for (int i = 1; i < int'(RD_LAT); i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[RD_LAT-1];

  // Expected per-cycle outputs, filled in when the model schedules a transaction.
  bit                e_cgnt [MAXC], e_dgnt [MAXC], e_crv [MAXC], e_drv [MAXC];
  bit                e_we [MAXC], e_re [MAXC], e_busy [MAXC];
  logic [ADDR_W-1:0] e_addr [MAXC];
  logic [DATA_W-1:0] e_wdata [MAXC], e_rvd [MAXC];
  logic [DATA_W-1:0] ref_mem [256];
  logic [DATA_W-1:0] x_crd, x_drd;
  int  free_at;
  bit  last_cpu;
  int  cyc;
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic clear_from(input int c);
    for (int k = c; k < MAXC; k++) begin
      e_cgnt[k] = 0; e_dgnt[k] = 0; e_crv[k] = 0; e_drv[k] = 0;
      e_we[k] = 0; e_re[k] = 0; e_busy[k] = 0;
      e_addr[k] = '0; e_wdata[k] = '0; e_rvd[k] = '0;
    end
  endtask

  // Applies the arbitration rules to the inputs presented in the current cycle.
  task automatic model_step();
    bit wc, we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd;
    if (reset) begin
      clear_from(cyc + 1);
      free_at  = cyc + 1;
      last_cpu = 1'b0;
      x_crd    = '0;
      x_drd    = '0;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    end else if (cyc >= free_at && (cpu_req || dsp_req)) begin
      wc = cpu_req && (!dsp_req || !last_cpu);
      we = wc ? cpu_we : dsp_we;
      a  = wc ? cpu_addr : dsp_addr;
      wd = wc ? cpu_wdata : dsp_wdata;
      e_cgnt[cyc+1] = wc;  e_dgnt[cyc+1] = !wc;
      e_we[cyc+1] = we;    e_re[cyc+1] = !we;
      e_addr[cyc+1] = a;   e_wdata[cyc+1] = wd;
      last_cpu = wc;
      if (we) begin
        ref_mem[a] = wd;
        free_at = cyc + 2;
      end else begin
        free_at = cyc + 2 + int'(RD_LAT);
        if (wc) e_crv[free_at] = 1; else e_drv[free_at] = 1;
        e_rvd[free_at] = ref_mem[a];
      end
      for (int k = cyc + 1; k < free_at; k++) e_busy[k] = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, want);
    end
  endtask

  task automatic check_cycle();
    if (e_crv[cyc]) x_crd = e_rvd[cyc];
    if (e_drv[cyc]) x_drd = e_rvd[cyc];
    chk("cpu_gnt", DATA_W'(cpu_gnt), DATA_W'(e_cgnt[cyc]));
    chk("dsp_gnt", DATA_W'(dsp_gnt), DATA_W'(e_dgnt[cyc]));
    chk("cpu_rvalid", DATA_W'(cpu_rvalid), DATA_W'(e_crv[cyc]));
    chk("dsp_rvalid", DATA_W'(dsp_rvalid), DATA_W'(e_drv[cyc]));
    chk("mem_we", DATA_W'(mem_we), DATA_W'(e_we[cyc]));
    chk("mem_re", DATA_W'(mem_re), DATA_W'(e_re[cyc]));
    chk("mem_addr", DATA_W'(mem_addr), DATA_W'(e_addr[cyc]));
    chk("mem_wdata", mem_wdata, e_wdata[cyc]);
    chk("busy", DATA_W'(busy), DATA_W'(e_busy[cyc]));
    chk("cpu_rdata", cpu_rdata, x_crd);
    chk("dsp_rdata", dsp_rdata, x_drd);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
  endtask

  initial begin
    int s;
    cyc = 0; free_at = 0; last_cpu = 1'b0;
    x_crd = '0; x_drd = '0;
    clear_from(0);
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dsp_req = 0; dsp_we = 0; dsp_addr = '0; dsp_wdata = '0;

    // Reset: everything quiet.
    repeat (3) tick();
    chk("rst_busy", DATA_W'(busy), '0);
    chk("rst_cpu_rdata", cpu_rdata, '0);
    reset = 1'b0;
    tick();

    // CPU write 0x10 <- DEADBEEF.
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h10; cpu_wdata = 32'hDEADBEEF;
    tick();
    chk("wr_cpu_gnt", DATA_W'(cpu_gnt), 1);
    chk("wr_mem_we", DATA_W'(mem_we), 1);
    chk("wr_mem_addr", DATA_W'(mem_addr), 32'h10);
    chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    cpu_req = 0;
    tick();
    chk("wr_busy_done", DATA_W'(busy), '0);

    // Display read of 0x10 with multi-cycle latency.
    dsp_req = 1; dsp_we = 0; dsp_addr = 8'h10;
    tick();
    chk("rd_dsp_gnt", DATA_W'(dsp_gnt), 1);
    chk("rd_mem_re", DATA_W'(mem_re), 1);
    dsp_req = 0;
    repeat (RD_LAT + 1) tick();
    chk("rd_dsp_rvalid", DATA_W'(dsp_rvalid), 1);
    chk("rd_dsp_rdata", dsp_rdata, 32'hDEADBEEF);
    chk("rd_cpu_rdata_kept", cpu_rdata, '0);
    repeat (2) tick();

    // Continuous contention: owners alternate cpu, dsp, ...
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
    dsp_req = 1; dsp_we = 0; dsp_addr = 8'h20;
    for (int k = 0; k < 6; k++) begin
      s = (k == 0) ? 1 : int'(2 + RD_LAT);
      repeat (s) tick();
      chk("rr_cpu_gnt", DATA_W'(cpu_gnt), DATA_W'(k % 2 == 0));
      chk("rr_dsp_gnt", DATA_W'(dsp_gnt), DATA_W'(k % 2 == 1));
    end
    cpu_req = 0; dsp_req = 0;
    repeat (8) tick();

    // Reset in the middle of a CPU read; the tie afterwards must go to the CPU.
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h30;
    tick();
    chk("rst_rd_gnt", DATA_W'(cpu_gnt), 1);
    cpu_req = 0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstw_busy", DATA_W'(busy), '0);
    chk("rstw_cpu_rvalid", DATA_W'(cpu_rvalid), '0);
    chk("rstw_mem_re", DATA_W'(mem_re), '0);
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h31; cpu_wdata = 32'h1111_2222;
    dsp_req = 1; dsp_we = 1; dsp_addr = 8'h32; dsp_wdata = 32'h3333_4444;
    tick();
    chk("rstw_tie_cpu", DATA_W'(cpu_gnt), 1);
    chk("rstw_tie_dsp", DATA_W'(dsp_gnt), '0);
    cpu_req = 0;
    tick();
    chk("rstw_no_rvalid", DATA_W'(cpu_rvalid), '0);
    tick();
    chk("rstw_dsp_next", DATA_W'(dsp_gnt), 1);
    dsp_req = 0;
    repeat (3) tick();

    // Display request pulsed only while a CPU write is in progress.
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h40; cpu_wdata = 32'hCAFE_0001;
    tick();
    cpu_req = 0;
    dsp_req = 1; dsp_we = 0; dsp_addr = 8'h55;
    tick();
    dsp_req = 0;
    repeat (6) begin
      tick();
      chk("drop_no_gnt", DATA_W'(dsp_gnt), '0);
      chk("drop_no_access", DATA_W'(mem_addr == 8'h55), '0);
    end

    // Randomized traffic against the schedule model.
    repeat (2000) begin
      reset = ($urandom_range(299, 0) == 0);
      if (e_cgnt[cyc]) begin
        if ($urandom_range(1, 0) == 0) cpu_req = 1'b0;
      end else if (cpu_req) begin
        if ($urandom_range(19, 0) == 0) cpu_req = 1'b0;
      end else if ($urandom_range(2, 0) == 0) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom_range(1, 0));
        cpu_addr = ADDR_W'($urandom_range(15, 0)); cpu_wdata = $urandom;
      end
      if (e_dgnt[cyc]) begin
        if ($urandom_range(1, 0) == 0) dsp_req = 1'b0;
      end else if (dsp_req) begin
        if ($urandom_range(19, 0) == 0) dsp_req = 1'b0;
      end else if ($urandom_range(2, 0) == 0) begin
        dsp_req = 1'b1; dsp_we = 1'($urandom_range(1, 0));
        dsp_addr = ADDR_W'($urandom_range(15, 0)); dsp_wdata = $urandom;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port instruction/data memory between the multicycle CPU controller and the display refresh engine. Each requester presents a single-word read or write request. The arbiter serializes the requests with round-robin fairness and drives the memory port. It returns read data with a one-cycle valid strobe to the requester that issued the read. It sits between the CPU memory-source mux, the display reader and the memory macro.

## Interface
- ADDR_W, 8, word address width
- DATA_W, 32, data width
- RD_LAT, 1, memory read latency in cycles from mem_re to valid mem_rdata; legal 1..4
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cpu_req / dsp_req  in  1  request, held until matching gnt
- cpu_we / dsp_we  in  1  1 = write, 0 = read; stable while req high
- cpu_addr / dsp_addr  in  ADDR_W  word address; stable while req high
- cpu_wdata / dsp_wdata  in  DATA_W  write data; stable while req high
- cpu_gnt / dsp_gnt  out  1  one-cycle pulse: request accepted, memory access in progress
- cpu_rvalid / dsp_rvalid  out  1  one-cycle pulse: rdata valid for this port
- cpu_rdata / dsp_rdata  out  DATA_W  registered read data, held until next read completes for that port
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write enable
- mem_re  out  1  memory read enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after mem_re
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ACCESS, WAIT.
- IDLE: sample the requests.
  - Neither requests: stay in IDLE.
  - One requests: that port wins.
  - Both request: winner is the port not granted last. The `last` register resets to dsp, so the CPU wins the first tie.
  - On a win: latch owner, we, addr, wdata; set `last` to the owner; go to ACCESS.
- ACCESS, one cycle:
  - Drive mem_addr and mem_wdata from the latched values. Assert mem_we = latched we and mem_re = !latched we.
  - Assert gnt for the owner only.
  - Write: next state IDLE.
  - Read: load latency counter with RD_LAT, next state WAIT.
- WAIT: decrement the counter each cycle.
  - On the cycle the counter equals 1, capture mem_rdata into the owner's rdata register.
  - On that same edge, set that port's rvalid for the next cycle and go to IDLE.
- Requests are sampled only in IDLE. A req dropped before its gnt is never served.
- The requester may deassert req in the gnt cycle. If req stays high after gnt, the arbiter treats it as a new request at the next IDLE.
- The non-owning port's rdata is never modified.
- mem_* outputs are 0 in every state except ACCESS.
- Reset:
  - All gnt, rvalid, mem_we, mem_re and busy are 0; all rdata are 0; state is IDLE; `last` is dsp.
  - Reset during WAIT discards the pending read. No rvalid is issued for it.

## Timing
- Request sampled in IDLE at cycle t. ACCESS, gnt and mem strobe occur in cycle t+1.
- Write: IDLE again in cycle t+2, so throughput is one write per 2 cycles.
- Read: mem_rdata is valid in cycle t+1+RD_LAT, rvalid is high in cycle t+2+RD_LAT, and the arbiter is in IDLE that same cycle.
  - A new request can be sampled in the rvalid cycle.
  - Read occupancy is 2+RD_LAT cycles.
- Back-to-back contention alternates owners strictly: cpu, dsp, cpu, …

## Test plan
- After reset, both ports idle, RD_LAT=1 -> all outputs 0, busy=0, state IDLE.
- cpu write, addr 0x10, data 0xDEADBEEF, at cycle 0 -> cycle 1: cpu_gnt=1, mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF; cycle 2: busy=0.
- dsp read of addr 0x10, memory model returns 0xDEADBEEF, RD_LAT=3 -> gnt cycle 1, mem_re=1 cycle 1, dsp_rvalid=1 in cycle 5 with dsp_rdata=0xDEADBEEF; cpu_rdata unchanged.
- Both ports request reads continuously, RD_LAT=1 -> grants go cpu, dsp, cpu, dsp, each 3 cycles apart; no port is granted twice in a row.
- Reset asserted during WAIT of a cpu read -> no cpu_rvalid, all outputs 0 the next cycle, and the next tie grants cpu.
- dsp_req raised for one cycle while the arbiter is busy with a cpu write, then dropped -> dsp_gnt never asserts and no memory access to the dsp address occurs.
